rob: RTL and testbench
======================

Name: rob

Overview:
- Reorder buffer that sits directly downstream of dispatch and directly upstream of the architectural register file.
- Allocates one tagged entry per dispatched instruction and captures results from the common data bus (CDB).
- Retires entries strictly in program order. Each retirement drives the register file's commit interface: ROB_commit, rd_s, and rd_v (ROB_idx, reg_value).
- On retirement of a mispredicted branch/jump, asserts flush and empties itself.

Parameters:
- ROB_DEPTH, 16, number of entries; power of two.
- IDX_W, $clog2(ROB_DEPTH), entry index width; equals the width of ROB_idx in rv32i_types.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- alloc_valid  in  1  dispatch requests an entry
- alloc_rd  in  5  destination architectural register
- alloc_ready  out  1  entry available this cycle
- alloc_idx  out  IDX_W  index granted (equals tail)
- cdb_valid  in  1  result broadcast
- cdb_rob_idx  in  IDX_W  tag of the broadcast result
- cdb_value  in  32  result value
- cdb_mispredict  in  1  broadcast result is a mispredicted branch/jump
- rs1_query_idx, rs2_query_idx  in  IDX_W  tags of busy source operands
- rs1_query_ready, rs2_query_ready  out  1  queried entry already holds its result
- rs1_query_value, rs2_query_value  out  32  value for the queried entry
- ROB_commit  out  1  head entry retires this cycle
- commit_rd  out  5  head destination; drives register file rd_s
- commit_rob_idx  out  IDX_W  head index; drives rd_v.ROB_idx
- commit_value  out  32  head result; drives rd_v.reg_value
- flush  out  1  mispredict recovery; same cycle as ROB_commit

Behaviour:
- State:
  - entry array {valid, ready, mispredict, rd[4:0], value[31:0]}
  - head, tail: IDX_W bits, wrap modulo ROB_DEPTH
  - count: IDX_W+1 bits
- Reset:
  - all entries valid=0; head=tail=count=0.
  - All outputs 0, except alloc_ready=1 in the first post-reset cycle with no flush.
- full = (count==ROB_DEPTH); empty = (count==0).
- Allocation:
  - alloc_ready = !full && !flush.
  - alloc_idx = tail, combinational.
  - If alloc_valid && alloc_ready: at the edge, entry[tail] gets {valid=1, ready=0, mispredict=0, rd=alloc_rd}; tail++.
  - alloc_valid while !alloc_ready is ignored; dispatch must hold its request.
  - A commit in the same cycle does NOT free a slot for that cycle's allocation (no same-cycle reuse when full).
- Writeback:
  - If cdb_valid && entry[cdb_rob_idx].valid: at the edge, set ready=1, value=cdb_value, mispredict=cdb_mispredict.
  - cdb_valid to an invalid entry is dropped silently.
- Commit:
  - ROB_commit = entry[head].valid && entry[head].ready, combinational.
  - commit_rd, commit_value and commit_rob_idx reflect the head entry; they are 0 when ROB_commit=0.
  - At the edge: entry[head].valid=0; head++.
  - Minimum latency is CDB at cycle N → ROB_commit at N+1. The ready bit is registered; there is no CDB-to-commit bypass.
  - rd=x0 entries still commit; the register file discards the value.
- Count: +1 on allocation only, −1 on commit only, unchanged when both occur.
- Flush:
  - flush = ROB_commit && entry[head].mispredict.
  - The branch's own result commits in that cycle.
  - At the edge: all entries valid=0; head=tail=count=0.
  - Allocation in a flush cycle is suppressed via alloc_ready=0.
  - A CDB write in a flush cycle is discarded.
- Operand query, per port, combinational:
  - If cdb_valid && cdb_rob_idx==query_idx: ready=1, value=cdb_value (CDB bypass).
  - Else: ready = entry.valid && entry.ready; value = entry.value.
  - value=0 when not ready.
- Wrap-around: head and tail roll from ROB_DEPTH-1 to 0; full and empty are distinguished by count, never by pointer equality.
- rst has priority over every other event, including mid-flush and a full buffer.

Decomposition:
- rv32i_types gains:
  - typedef rob_entry_t {valid, ready, mispredict, rd, value}
  - localparam ROB_DEPTH
  - ROB index width, shared with RegFile_t.ROB_idx and ROBinfo_t
- No sub-module. The entry array, pointer logic and query muxes stay in rob.

Test Plan:
- Reset, allocate 3 (rd=1,2,3) → alloc_idx 0,1,2; count=3; ROB_commit=0.
- CDB idx1=0xBEEF then idx0=0x1234 → commit idx0 (rd=1, 0x1234) then idx1 (rd=2, 0xBEEF) on consecutive cycles; idx2 stays pending.
- Fill to 16 → alloc_ready=0; commit+alloc_valid same cycle → no allocation. Next cycle alloc_idx=0 and tail wraps 15→0.
- Query idx5 while CDB broadcasts idx5=0xCAFE → rs1_query_ready=1, value 0xCAFE in the same cycle. Next cycle the same value is served from the entry.
- Branch at idx2 with cdb_mispredict=1, entries 3..6 valid → at idx2 commit, ROB_commit=flush=1. Next cycle count=0, head=tail=0, alloc_ready=1; a concurrent CDB write to idx4 is lost.
- rst asserted while full with pending CDB → next cycle count=0, all outputs 0, alloc_ready=1.

Source files
------------

// File: rtl/rob_pkg.sv
// rob_pkg: shared types and sizing for the reorder buffer.
//   ROB_DEPTH   - number of in-flight entries (power of two)
//   ROB_IDX_W   - tag width; matches the register file's ROB_idx field
//   rob_entry_t - one buffer slot: {valid, ready, mispredict, rd, value}
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

  typedef struct packed {
    logic        valid;
    logic        ready;
    logic        mispredict;
    logic [4:0]  rd;
    logic [31:0] value;
  } rob_entry_t;

endpackage

// File: rtl/rob.sv
// rob: in-order reorder buffer between dispatch and the register file.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   alloc_valid/alloc_rd          - dispatch request and destination reg
//   alloc_ready/alloc_idx         - slot available / granted tag (= tail)
//   cdb_valid/rob_idx/value/mispredict - result broadcast from the CDB
//   rs{1,2}_query_idx             - tags of busy source operands
//   rs{1,2}_query_ready/value     - operand available (with CDB bypass)
//   ROB_commit, commit_rd/rob_idx/value - head retirement to the regfile
//   flush                         - head is a mispredicted branch; empties the buffer
module rob #(
  parameter int ROB_DEPTH = rob_pkg::ROB_DEPTH,
  parameter int IDX_W     = $clog2(ROB_DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             cdb_valid,
  input  logic [IDX_W-1:0] cdb_rob_idx,
  input  logic [31:0]      cdb_value,
  input  logic             cdb_mispredict,
  input  logic [IDX_W-1:0] rs1_query_idx,
  input  logic [IDX_W-1:0] rs2_query_idx,
  output logic             rs1_query_ready,
  output logic             rs2_query_ready,
  output logic [31:0]      rs1_query_value,
  output logic [31:0]      rs2_query_value,
  output logic             ROB_commit,
  output logic [4:0]       commit_rd,
  output logic [IDX_W-1:0] commit_rob_idx,
  output logic [31:0]      commit_value,
  output logic             flush
);
  import rob_pkg::*;

  rob_entry_t entries_q [ROB_DEPTH];
  rob_entry_t entries_d [ROB_DEPTH];
  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  logic       full;
  logic       do_alloc;
  rob_entry_t head_e;

  assign full     = (count_q == (IDX_W+1)'(ROB_DEPTH));
  assign head_e   = entries_q[head_q];

  assign ROB_commit     = head_e.valid && head_e.ready;
  assign flush          = ROB_commit && head_e.mispredict;
  assign commit_rd      = ROB_commit ? head_e.rd    : 5'd0;
  assign commit_value   = ROB_commit ? head_e.value : 32'd0;
  assign commit_rob_idx = ROB_commit ? head_q       : '0;

  // A commit this cycle does not free a slot until next cycle.
  assign alloc_ready = !full && !flush;
  assign alloc_idx   = tail_q;
  assign do_alloc    = alloc_valid && alloc_ready;

  // Operand lookup: a same-cycle CDB broadcast wins over stored state.
  always_comb begin
    rs1_query_ready = 1'b0;
    rs1_query_value = 32'd0;
    if (cdb_valid && cdb_rob_idx == rs1_query_idx) begin
      rs1_query_ready = 1'b1;
      rs1_query_value = cdb_value;
    end else if (entries_q[rs1_query_idx].valid && entries_q[rs1_query_idx].ready) begin
      rs1_query_ready = 1'b1;
      rs1_query_value = entries_q[rs1_query_idx].value;
    end
  end

  always_comb begin
    rs2_query_ready = 1'b0;
    rs2_query_value = 32'd0;
    if (cdb_valid && cdb_rob_idx == rs2_query_idx) begin
      rs2_query_ready = 1'b1;
      rs2_query_value = cdb_value;
    end else if (entries_q[rs2_query_idx].valid && entries_q[rs2_query_idx].ready) begin
      rs2_query_ready = 1'b1;
      rs2_query_value = entries_q[rs2_query_idx].value;
    end
  end

  // Next-state for the entry array. Writeback precedes the commit clear so a
  // late broadcast to the retiring head cannot resurrect it.
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) entries_d[i] = entries_q[i];
    if (flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries_d[i].valid = 1'b0;
    end else begin
      if (cdb_valid && entries_q[cdb_rob_idx].valid) begin
        entries_d[cdb_rob_idx].ready      = 1'b1;
        entries_d[cdb_rob_idx].value      = cdb_value;
        entries_d[cdb_rob_idx].mispredict = cdb_mispredict;
      end
      if (ROB_commit) entries_d[head_q].valid = 1'b0;
      if (do_alloc) begin
        entries_d[tail_q].valid      = 1'b1;
        entries_d[tail_q].ready      = 1'b0;
        entries_d[tail_q].mispredict = 1'b0;
        entries_d[tail_q].rd         = alloc_rd;
      end
    end
  end

  // Pointers wrap naturally at IDX_W bits; occupancy comes from count only.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (ROB_commit) head_d = head_q + IDX_W'(1);
      if (do_alloc)   tail_d = tail_q + IDX_W'(1);
      case ({do_alloc, ROB_commit})
        2'b10:   count_d = count_q + (IDX_W+1)'(1);
        2'b01:   count_d = count_q - (IDX_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) entries_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) entries_q[i] <= entries_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_rob.sv
// tb_rob: directed self-checking bench for the reorder buffer.
module tb_rob;
  localparam int D = 16;
  localparam int W = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic [4:0]    alloc_rd;
  logic          alloc_ready;
  logic [W-1:0]  alloc_idx;
  logic          cdb_valid;
  logic [W-1:0]  cdb_rob_idx;
  logic [31:0]   cdb_value;
  logic          cdb_mispredict;
  logic [W-1:0]  rs1_query_idx, rs2_query_idx;
  logic          rs1_query_ready, rs2_query_ready;
  logic [31:0]   rs1_query_value, rs2_query_value;
  logic          ROB_commit;
  logic [4:0]    commit_rd;
  logic [W-1:0]  commit_rob_idx;
  logic [31:0]   commit_value;
  logic          flush;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rob #(.ROB_DEPTH(D), .IDX_W(W)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx),
    .cdb_value(cdb_value), .cdb_mispredict(cdb_mispredict),
    .rs1_query_idx(rs1_query_idx), .rs2_query_idx(rs2_query_idx),
    .rs1_query_ready(rs1_query_ready), .rs2_query_ready(rs2_query_ready),
    .rs1_query_value(rs1_query_value), .rs2_query_value(rs2_query_value),
    .ROB_commit(ROB_commit), .commit_rd(commit_rd),
    .commit_rob_idx(commit_rob_idx), .commit_value(commit_value),
    .flush(flush)
  );

  // Advance one clock; inputs return to idle 1 ns after the edge.
  task automatic cyc();
    @(posedge clk); #1;
    alloc_valid = 0; alloc_rd = 0;
    cdb_valid = 0; cdb_rob_idx = 0; cdb_value = 0; cdb_mispredict = 0;
  endtask

  task automatic do_reset();
    rst = 1; cyc(); rst = 0;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_valid = 1; alloc_rd = 5'(i); cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1; alloc_valid = 0; alloc_rd = 0; cdb_valid = 0; cdb_rob_idx = 0;
    cdb_value = 0; cdb_mispredict = 0; rs1_query_idx = 0; rs2_query_idx = 0;
    cyc(); cyc(); rst = 0;
    @(negedge clk);
    tests++; if (alloc_ready !== 1'b1) begin fails++; $display("FAIL reset_alloc_ready got %0b exp 1", alloc_ready); end
    tests++; if (alloc_idx !== 4'd0) begin fails++; $display("FAIL reset_alloc_idx got %0d exp 0", alloc_idx); end
    tests++; if ({ROB_commit, flush, commit_rd, commit_value} !== '0) begin fails++; $display("FAIL reset_commit_outs got %0b/%0b/%0d/%0h exp 0", ROB_commit, flush, commit_rd, commit_value); end
    tests++; if (dut.count_q !== 5'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", dut.count_q); end
    cyc();
  endtask

  task automatic test_alloc();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1; alloc_rd = 5'(i + 1);
      @(negedge clk);
      tests++; if (alloc_idx !== 4'(i)) begin fails++; $display("FAIL alloc_idx%0d got %0d exp %0d", i, alloc_idx, i); end
      cyc();
    end
    @(negedge clk);
    tests++; if (dut.count_q !== 5'd3) begin fails++; $display("FAIL alloc_count got %0d exp 3", dut.count_q); end
    tests++; if (ROB_commit !== 1'b0) begin fails++; $display("FAIL alloc_no_commit got %0b exp 0", ROB_commit); end
    cyc();
  endtask

  task automatic test_inorder_commit();
    cdb_valid = 1; cdb_rob_idx = 1; cdb_value = 32'hBEEF; cyc();
    cdb_valid = 1; cdb_rob_idx = 0; cdb_value = 32'h1234;
    @(negedge clk);
    tests++; if (ROB_commit !== 1'b0) begin fails++; $display("FAIL no_cdb_bypass got %0b exp 0", ROB_commit); end
    cyc();
    @(negedge clk);
    tests++; if ({ROB_commit, commit_rd, commit_rob_idx, commit_value} !== {1'b1, 5'd1, 4'd0, 32'h1234})
      begin fails++; $display("FAIL commit0 got %0b rd%0d idx%0d %0h exp 1 rd1 idx0 1234", ROB_commit, commit_rd, commit_rob_idx, commit_value); end
    cyc();
    @(negedge clk);
    tests++; if ({ROB_commit, commit_rd, commit_rob_idx, commit_value} !== {1'b1, 5'd2, 4'd1, 32'hBEEF})
      begin fails++; $display("FAIL commit1 got %0b rd%0d idx%0d %0h exp 1 rd2 idx1 beef", ROB_commit, commit_rd, commit_rob_idx, commit_value); end
    cyc();
    @(negedge clk);
    tests++; if ({ROB_commit, commit_value} !== 33'd0) begin fails++; $display("FAIL idx2_pending got %0b %0h exp 0 0", ROB_commit, commit_value); end
    tests++; if (dut.count_q !== 5'd1) begin fails++; $display("FAIL pending_count got %0d exp 1", dut.count_q); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < D; i++) begin
      alloc_valid = 1; alloc_rd = 5'(i);
      @(negedge clk);
      if (alloc_idx !== 4'(i)) begin tests++; fails++; $display("FAIL fill_idx%0d got %0d exp %0d", i, alloc_idx, i); end
      cyc();
    end
    @(negedge clk);
    tests++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL full_alloc_ready got %0b exp 0", alloc_ready); end
    tests++; if (dut.count_q !== 5'd16) begin fails++; $display("FAIL full_count got %0d exp 16", dut.count_q); end
    cdb_valid = 1; cdb_rob_idx = 0; cdb_value = 32'h55; cyc();
    alloc_valid = 1; alloc_rd = 5'd9;
    @(negedge clk);
    tests++; if ({ROB_commit, alloc_ready} !== 2'b10) begin fails++; $display("FAIL full_commit_alloc got %0b%0b exp 10", ROB_commit, alloc_ready); end
    cyc();
    @(negedge clk);
    tests++; if (dut.count_q !== 5'd15) begin fails++; $display("FAIL full_no_reuse_count got %0d exp 15", dut.count_q); end
    tests++; if ({alloc_ready, alloc_idx} !== {1'b1, 4'd0}) begin fails++; $display("FAIL wrap_idx got %0b/%0d exp 1/0", alloc_ready, alloc_idx); end
    alloc_valid = 1; alloc_rd = 5'd7; cyc();
    @(negedge clk);
    tests++; if ({dut.tail_q, dut.count_q} !== {4'd1, 5'd16}) begin fails++; $display("FAIL wrap_tail got %0d/%0d exp 1/16", dut.tail_q, dut.count_q); end
  endtask

  task automatic test_query_bypass();
    rs1_query_idx = 5; rs2_query_idx = 6;
    cdb_valid = 1; cdb_rob_idx = 5; cdb_value = 32'hCAFE;
    @(negedge clk);
    tests++; if ({rs1_query_ready, rs1_query_value} !== {1'b1, 32'hCAFE}) begin fails++; $display("FAIL query_bypass got %0b %0h exp 1 cafe", rs1_query_ready, rs1_query_value); end
    tests++; if ({rs2_query_ready, rs2_query_value} !== 33'd0) begin fails++; $display("FAIL query_not_ready got %0b %0h exp 0 0", rs2_query_ready, rs2_query_value); end
    cyc();
    @(negedge clk);
    tests++; if ({rs1_query_ready, rs1_query_value} !== {1'b1, 32'hCAFE}) begin fails++; $display("FAIL query_stored got %0b %0h exp 1 cafe", rs1_query_ready, rs1_query_value); end
  endtask

  task automatic test_flush();
    do_reset();
    fill(7);
    cdb_valid = 1; cdb_rob_idx = 0; cdb_value = 32'hA; cyc();
    cdb_valid = 1; cdb_rob_idx = 1; cdb_value = 32'hB; cyc();
    cdb_valid = 1; cdb_rob_idx = 2; cdb_value = 32'hC; cdb_mispredict = 1; cyc();
    // Head is now the mispredicted branch; a CDB write and an allocation race it.
    cdb_valid = 1; cdb_rob_idx = 4; cdb_value = 32'hDD; alloc_valid = 1; alloc_rd = 5'd30;
    @(negedge clk);
    tests++; if ({ROB_commit, flush, alloc_ready} !== 3'b110) begin fails++; $display("FAIL flush_flags got %0b%0b%0b exp 110", ROB_commit, flush, alloc_ready); end
    tests++; if ({commit_rd, commit_rob_idx, commit_value} !== {5'd2, 4'd2, 32'hC}) begin fails++; $display("FAIL flush_commit got rd%0d idx%0d %0h exp rd2 idx2 c", commit_rd, commit_rob_idx, commit_value); end
    cyc();
    rs1_query_idx = 4; rs2_query_idx = 3;
    @(negedge clk);
    tests++; if ({dut.count_q, dut.head_q, dut.tail_q} !== 13'd0) begin fails++; $display("FAIL flush_ptrs got %0d/%0d/%0d exp 0/0/0", dut.count_q, dut.head_q, dut.tail_q); end
    tests++; if ({alloc_ready, alloc_idx, ROB_commit, flush} !== {1'b1, 4'd0, 2'b00}) begin fails++; $display("FAIL flush_after got %0b/%0d/%0b/%0b exp 1/0/0/0", alloc_ready, alloc_idx, ROB_commit, flush); end
    tests++; if ({rs1_query_ready, rs1_query_value} !== 33'd0) begin fails++; $display("FAIL flush_cdb_lost got %0b %0h exp 0 0", rs1_query_ready, rs1_query_value); end
    cyc();
  endtask

  task automatic test_reset_full();
    do_reset();
    fill(D);
    cdb_valid = 1; cdb_rob_idx = 0; cdb_value = 32'h77; rst = 1; cyc();
    rst = 0; rs1_query_idx = 0; rs2_query_idx = 1;
    @(negedge clk);
    tests++; if (dut.count_q !== 5'd0) begin fails++; $display("FAIL rst_full_count got %0d exp 0", dut.count_q); end
    tests++; if ({alloc_ready, alloc_idx} !== {1'b1, 4'd0}) begin fails++; $display("FAIL rst_full_alloc got %0b/%0d exp 1/0", alloc_ready, alloc_idx); end
    tests++; if ({ROB_commit, flush, commit_rd, commit_rob_idx, commit_value, rs1_query_ready, rs1_query_value} !== '0)
      begin fails++; $display("FAIL rst_full_outs got %0b%0b rd%0d idx%0d %0h q%0b %0h exp all 0", ROB_commit, flush, commit_rd, commit_rob_idx, commit_value, rs1_query_ready, rs1_query_value); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_inorder_commit();
    test_full_wrap();
    test_query_bypass();
    test_flush();
    test_reset_full();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
